// File: rtl/gcd_operand_feeder_if.sv
// Handshake and core-bus bundle for the GCD operand feeder.
// master: the feeder; slave: the environment (requester, consumer, core).
interface gcd_operand_feeder_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_gcd;
   logic         out_err;
   logic         core_start;
   logic [W-1:0] core_data;
   logic         core_done;
   logic [W-1:0] core_result;

   modport master (
      input  in_valid, in_a, in_b, out_ready, core_done, core_result,
      output in_ready, out_valid, out_gcd, out_err, core_start, core_data
   );

   modport slave (
      output in_valid, in_a, in_b, out_ready, core_done, core_result,
      input  in_ready, out_valid, out_gcd, out_err, core_start, core_data
   );
endinterface

// File: rtl/gcd_operand_feeder.sv
// Drives the GCD core start/serial-load protocol for one operand pair,
// bypasses zero operands and times out on a hung core.
module gcd_operand_feeder #(
   parameter int W       = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   gcd_operand_feeder_if.master  bus,
   output logic                  busy
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_LOAD_B,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  gcd_q, gcd_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // State, operand, result and timeout registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: accept, load A then B, wait for done or timeout, respond
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid && !bus.core_done) begin
               a_d = bus.in_a;
               b_d = bus.in_b;
               if ((bus.in_a == '0) || (bus.in_b == '0)) begin
                  gcd_d   = bus.in_a | bus.in_b;
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.core_done) begin
               gcd_d   = bus.core_result;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               gcd_d   = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      bus.in_ready   = (state_q == S_IDLE) && !bus.core_done && !rst;
      bus.out_valid  = (state_q == S_RESP);
      bus.out_gcd    = gcd_q;
      bus.out_err    = err_q;
      bus.core_start = (state_q == S_START) ||
                       (state_q == S_LOAD_B) ||
                       (state_q == S_WAIT);
      bus.core_data  = '0;
      if (state_q == S_START) begin
         bus.core_data = a_q;
      end else if ((state_q == S_LOAD_B) || (state_q == S_WAIT)) begin
         bus.core_data = b_q;
      end
      busy = (state_q != S_IDLE);
   end
endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Randomised self-checking bench for gcd_operand_feeder with a
// behavioural GCD core model and a Euclid reference.
module tb_gcd_operand_feeder;
   localparam int W  = 16;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int   core_lat = 2;
   bit   core_respond = 1'b1;
   int   hold_req = 0;
   int   starts = 0;
   int   start_cyc = 0;
   logic [W-1:0] ma, mb;

   gcd_operand_feeder_if #(.W(W)) bus ();

   gcd_operand_feeder #(.W(W), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned ref_gcd(input int unsigned a,
                                           input int unsigned b);
      int unsigned x = a;
      int unsigned y = b;
      while (y != 0) begin
         int unsigned t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Behavioural core: start+A, then B, then done after a latency
   initial begin
      int ph = 0;
      int lat = 0;
      int hold = 0;
      bus.core_done = 1'b0;
      bus.core_result = '0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.core_start === 1'b1) begin
            start_cyc++;
            if (ph == 0) begin
               ma = bus.core_data;
               ph = 1;
               starts++;
            end else if (ph == 1) begin
               mb = bus.core_data;
               ph = 2;
               lat = core_lat;
            end else if (core_respond && !bus.core_done) begin
               if (lat == 0) begin
                  bus.core_done = 1'b1;
                  bus.core_result = W'(ref_gcd(ma, mb));
                  hold = hold_req;
               end else begin
                  lat--;
               end
            end
         end else begin
            ph = 0;
            if (bus.core_done) begin
               if (hold > 0) hold--;
               else bus.core_done = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int acc);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a = a;
      bus.in_b = b;
      for (int i = 0; i < 100; i++) begin
         ok = (bus.in_ready === 1'b1);
         @(negedge clk);
         if (ok) break;
      end
      bus.in_valid = 1'b0;
      acc = cyc;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept: in_ready stayed %b, required 1", bus.in_ready);
      end
   endtask

   task automatic wait_out(output int at);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      at = cyc;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL out_valid: got %b, required 1 within bound",
                  bus.out_valid);
      end
   endtask

   task automatic take_out();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_gcd, bus.out_err,
           bus.core_start, bus.core_data, busy} !== '0) begin
         errors++;
         $display("FAIL reset_vals: rdy=%b ov=%b g=%0d e=%b st=%b d=%0d bz=%b, required all 0",
                  bus.in_ready, bus.out_valid, bus.out_gcd, bus.out_err,
                  bus.core_start, bus.core_data, busy);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset: in_ready=%b busy=%b, required 1 0",
                  bus.in_ready, busy);
      end
   endtask

   task automatic test_basic();
      int acc, at;
      core_lat = 3;
      send(16'd143, 16'd78, acc);
      checks++;
      if ({bus.core_start, bus.core_data} !== {1'b1, 16'd143}) begin
         errors++;
         $display("FAIL load_a: start=%b data=%0d, required 1 143",
                  bus.core_start, bus.core_data);
      end
      @(negedge clk);
      checks++;
      if ({bus.core_start, bus.core_data} !== {1'b1, 16'd78}) begin
         errors++;
         $display("FAIL load_b: start=%b data=%0d, required 1 78",
                  bus.core_start, bus.core_data);
      end
      wait_out(at);
      checks++;
      if ({bus.out_gcd, bus.out_err} !== {16'd13, 1'b0}) begin
         errors++;
         $display("FAIL basic_gcd: gcd=%0d err=%b, required 13 0",
                  bus.out_gcd, bus.out_err);
      end
      take_out();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drop: out_valid=%b, required 0", bus.out_valid);
      end
   endtask

   task automatic test_zero();
      logic [W-1:0] za [3] = '{16'd0, 16'd42, 16'd0};
      logic [W-1:0] zb [3] = '{16'd42, 16'd0, 16'd0};
      logic [W-1:0] zg [3] = '{16'd42, 16'd42, 16'd0};
      int s0, acc, at;
      s0 = start_cyc;
      for (int i = 0; i < 3; i++) begin
         send(za[i], zb[i], acc);
         wait_out(at);
         checks++;
         if ({at - acc, bus.out_gcd, bus.out_err} !== {32'd0, zg[i], 1'b0}) begin
            errors++;
            $display("FAIL zero_%0d: lat=%0d gcd=%0d err=%b, required 0 %0d 0",
                     i, at - acc, bus.out_gcd, bus.out_err, zg[i]);
         end
         take_out();
      end
      checks++;
      if (start_cyc !== s0) begin
         errors++;
         $display("FAIL zero_nostart: start cycles=%0d, required %0d",
                  start_cyc, s0);
      end
   endtask

   task automatic test_timeout();
      int acc, at;
      core_respond = 1'b0;
      send(16'd12, 16'd8, acc);
      wait_out(at);
      checks++;
      if (at - acc !== 2 + TO) begin
         errors++;
         $display("FAIL timeout_lat: %0d edges, required %0d", at - acc, 2 + TO);
      end
      checks++;
      if ({bus.out_gcd, bus.out_err, bus.core_start} !== {16'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL timeout_val: gcd=%0d err=%b start=%b, required 0 1 0",
                  bus.out_gcd, bus.out_err, bus.core_start);
      end
      take_out();
      core_respond = 1'b1;
   endtask

   task automatic test_back_to_back();
      int acc, at, bad, s0;
      core_lat = 1;
      send(16'd48, 16'd18, acc);
      wait_out(at);
      bus.in_valid = 1'b1;
      bus.in_a = 16'd35;
      bus.in_b = 16'd10;
      s0 = starts;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if ({bus.out_valid, bus.out_gcd, bus.out_err, bus.in_ready}
             !== {1'b1, 16'd6, 1'b0, 1'b0}) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0 || starts != s0) begin
         errors++;
         $display("FAIL hold_result: %0d bad cycles, starts %0d, required 0 and %0d",
                  bad, starts, s0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL release: ov=%b rdy=%b busy=%b, required 0 1 0",
                  bus.out_valid, bus.in_ready, busy);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if ({busy, bus.core_start, bus.core_data, starts}
          !== {1'b1, 1'b1, 16'd35, s0 + 1}) begin
         errors++;
         $display("FAIL next_accept: busy=%b st=%b d=%0d starts=%0d, required 1 1 35 %0d",
                  busy, bus.core_start, bus.core_data, starts, s0 + 1);
      end
      wait_out(at);
      checks++;
      if (bus.out_gcd !== 16'd5) begin
         errors++;
         $display("FAIL next_gcd: got %0d, required 5", bus.out_gcd);
      end
      take_out();
   endtask

   task automatic test_mid_reset();
      int acc, at, seen;
      core_lat = 20;
      send(16'd100, 16'd75, acc);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_gcd, bus.out_err,
           bus.core_start, bus.core_data, busy} !== '0) begin
         errors++;
         $display("FAIL midrst_vals: ov=%b g=%0d st=%b d=%0d bz=%b, required all 0",
                  bus.out_valid, bus.out_gcd, bus.core_start, bus.core_data, busy);
      end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.out_valid !== 1'b0 || bus.core_start !== 1'b0) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midrst_quiet: %0d active cycles, required 0", seen);
      end
      core_lat = 2;
      send(16'd21, 16'd14, acc);
      wait_out(at);
      checks++;
      if ({bus.out_gcd, bus.out_err} !== {16'd7, 1'b0}) begin
         errors++;
         $display("FAIL midrst_next: gcd=%0d err=%b, required 7 0",
                  bus.out_gcd, bus.out_err);
      end
      take_out();
   endtask

   task automatic test_done_hold();
      int acc, at, blocked, bad, c0;
      bit ok;
      hold_req = 5;
      core_lat = 1;
      send(16'd9, 16'd6, acc);
      wait_out(at);
      take_out();
      hold_req = 0;
      blocked = 0;
      bad = 0;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.in_ready !== !bus.core_done) bad++;
         if (bus.core_done === 1'b1) blocked++;
         else begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      c0 = cyc;
      checks++;
      if (!ok || blocked == 0 || bad != 0) begin
         errors++;
         $display("FAIL done_block: ok=%b blocked=%0d bad=%0d, required 1 >0 0",
                  ok, blocked, bad);
      end
      send(16'd27, 16'd18, acc);
      checks++;
      if (acc != c0 + 1) begin
         errors++;
         $display("FAIL done_accept: edge %0d, required %0d", acc, c0 + 1);
      end
      wait_out(at);
      checks++;
      if (bus.out_gcd !== 16'd9) begin
         errors++;
         $display("FAIL done_gcd: got %0d, required 9", bus.out_gcd);
      end
      take_out();
   endtask

   task automatic test_random();
      int acc, at, s0;
      logic [W-1:0] a, b;
      logic [W-1:0] exp_g;
      for (int n = 0; n < 24; n++) begin
         a = W'($urandom_range(1, 1000));
         b = W'($urandom_range(1, 1000));
         if ($urandom_range(0, 9) == 0) a = '0;
         if ($urandom_range(0, 9) == 0) b = '0;
         core_lat = $urandom_range(0, 8);
         exp_g = W'(ref_gcd(a, b));
         s0 = starts;
         send(a, b, acc);
         wait_out(at);
         checks++;
         if ({bus.out_gcd, bus.out_err} !== {exp_g, 1'b0}) begin
            errors++;
            $display("FAIL rand_%0d: gcd(%0d,%0d)=%0d err=%b, required %0d 0",
                     n, a, b, bus.out_gcd, bus.out_err, exp_g);
         end
         checks++;
         if (starts != s0 + ((a == 0 || b == 0) ? 0 : 1)) begin
            errors++;
            $display("FAIL rand_start_%0d: starts=%0d, required %0d",
                     n, starts - s0, (a == 0 || b == 0) ? 0 : 1);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         take_out();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_timeout();
      test_back_to_back();
      test_mid_reset();
      test_done_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
